// File: rtl/median_pkg.sv
// Shared types and width helpers for the median filter path.
package median_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;

  typedef logic [DW_DEF-1:0] pixel_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CW_DEF = cnt_w(IMG_W_DEF);
  localparam int unsigned RW_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/median_line_buf.sv
// One image line of storage: combinational read, synchronous write at the
// same address, so a read in the write cycle returns the previous row.
module median_line_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Old contents are visible until the edge that overwrites them.
  assign o_rdata = r_mem[i_addr];

  // Storage is intentionally not reset; stale rows are never exposed as valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/median_win_col3.sv
// Vertical 3-pixel column generator: two line buffers plus raster counters,
// emitting top/middle/bottom pixels with position and framing flags.
module median_win_col3
  import median_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             pix_i,
  input  logic                      pix_vld_i,
  input  logic                      sof_i,
  output logic [DW-1:0]             d1_o,
  output logic [DW-1:0]             d2_o,
  output logic [DW-1:0]             d3_o,
  output logic                      vld_o,
  output logic [cnt_w(IMG_H)-1:0]   row_o,
  output logic [cnt_w(IMG_W)-1:0]   col_o,
  output logic                      eol_o,
  output logic                      eof_o
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_WIN  = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win;
  logic          w_we;
  logic [DW-1:0] w_lb0;
  logic [DW-1:0] w_lb1;

  // Position of the pixel being accepted; sof restarts the frame at (0,0).
  assign w_col      = sof_i ? '0 : r_col;
  assign w_row      = sof_i ? '0 : r_row;
  assign w_col_last = (w_col == C_LAST);
  assign w_row_last = (w_row == R_LAST);
  assign w_win      = (w_row >= R_WIN);
  assign w_we       = pix_vld_i & ~rst;

  // lb0 holds row r-1, lb1 holds row r-2; lb1 takes lb0's pre-write value.
  median_line_buf #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_col),
    .i_wdata (pix_i),
    .o_rdata (w_lb0)
  );

  median_line_buf #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_col),
    .i_wdata (w_lb0),
    .o_rdata (w_lb1)
  );

  // Raster counters, wrapping at end of line and end of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_vld_i) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Output column register; flags drop on idle cycles, data and position hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_o  <= '0;
      d2_o  <= '0;
      d3_o  <= '0;
      row_o <= '0;
      col_o <= '0;
      vld_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
    end else begin
      vld_o <= 1'b0;
      eol_o <= 1'b0;
      eof_o <= 1'b0;
      if (pix_vld_i) begin
        d1_o  <= w_lb1;
        d2_o  <= w_lb0;
        d3_o  <= pix_i;
        row_o <= w_row;
        col_o <= w_col;
        vld_o <= w_win;
        eol_o <= w_win & w_col_last;
        eof_o <= w_win & w_col_last & w_row_last;
      end
    end
  end

endmodule

// File: tb/tb_median_win_col3.sv
// Randomized self-checking bench for median_win_col3 on a 4x4 image.
module tb_median_win_col3;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pix_i;
  logic          pix_vld_i;
  logic          sof_i;
  logic [DW-1:0] d1_o, d2_o, d3_o;
  logic          vld_o, eol_o, eof_o;
  logic [1:0]    row_o;
  logic [1:0]    col_o;

  median_win_col3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_i     (pix_i),
    .pix_vld_i (pix_vld_i),
    .sof_i     (sof_i),
    .d1_o      (d1_o),
    .d2_o      (d2_o),
    .d3_o      (d3_o),
    .vld_o     (vld_o),
    .row_o     (row_o),
    .col_o     (col_o),
    .eol_o     (eol_o),
    .eof_o     (eof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a linear raster index plus, per column, the last two pixels seen.
  int unsigned idx;
  int          hist1 [W];
  int          hist2 [W];
  int          e_d1, e_d2, e_d3, e_row, e_col, e_vld, e_eol, e_eof;
  bit          e_dknown;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic step(input bit r_, input bit v, input bit s, input int p);
    int r, c;
    @(negedge clk);
    rst = r_; pix_vld_i = v; sof_i = s; pix_i = DW'(p);
    @(posedge clk);
    if (r_) begin
      idx = 0;
      e_d1 = 0; e_d2 = 0; e_d3 = 0; e_row = 0; e_col = 0;
      e_vld = 0; e_eol = 0; e_eof = 0; e_dknown = 1'b1;
    end else if (v) begin
      if (s) idx = 0;
      r = int'(idx / W);
      c = int'(idx % W);
      e_d1 = hist2[c]; e_d2 = hist1[c]; e_d3 = p;
      hist2[c] = hist1[c]; hist1[c] = p;
      e_row = r; e_col = c;
      e_vld = (r >= 2) ? 1 : 0;
      e_eol = (r >= 2 && c == W - 1) ? 1 : 0;
      e_eof = (r >= 2 && idx == W * H - 1) ? 1 : 0;
      e_dknown = (r >= 2);
      idx = (idx + 1) % (W * H);
    end else begin
      e_vld = 0; e_eol = 0; e_eof = 0;
    end
    #1;
    rst = 1'b0; pix_vld_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic px(input int r, input int c, input bit s);
    step(1'b0, 1'b1, s, 16 * r + c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Compare every cycle against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("vld", int'(vld_o), e_vld);
      check("eol", int'(eol_o), e_eol);
      check("eof", int'(eof_o), e_eof);
      check("row", int'(row_o), e_row);
      check("col", int'(col_o), e_col);
      if (e_dknown) begin
        check("d3", int'(d3_o), e_d3);
        check("d2", int'(d2_o), e_d2);
        check("d1", int'(d1_o), e_d1);
      end
    end
  end

  // Hand-computed expectations against the DUT, sampled mid-cycle.
  task automatic pin(input string tag, input int v, input int a, input int b,
                     input int d, input int r, input int c, input int eol,
                     input int eof);
    check({tag, ".vld"}, int'(vld_o), v);
    check({tag, ".d1"},  int'(d1_o),  a);
    check({tag, ".d2"},  int'(d2_o),  b);
    check({tag, ".d3"},  int'(d3_o),  d);
    check({tag, ".row"}, int'(row_o), r);
    check({tag, ".col"}, int'(col_o), c);
    check({tag, ".eol"}, int'(eol_o), eol);
    check({tag, ".eof"}, int'(eof_o), eof);
  endtask

  initial begin
    rst = 1'b1; pix_vld_i = 1'b0; sof_i = 1'b0; pix_i = '0;
    idx = 0;
    for (int i = 0; i < W; i++) begin hist1[i] = 0; hist2[i] = 0; end
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk_en = 1'b1;
    pin("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Continuous frame with sof on the first pixel.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px(r, c, (r == 0 && c == 0));
        if (r < 2) check("early_vld", int'(vld_o), 0);
        if (r == 2 && c == 0) pin("first_col", 1, 0, 16, 32, 2, 0, 0, 0);
      end
    end
    pin("last_col", 1, 19, 35, 51, 3, 3, 1, 1);
    idle(1);
    check("idle_vld", int'(vld_o), 0);
    check("idle_hold_d3", int'(d3_o), 51);

    // Same frame with random gaps, no sof (counters already wrapped).
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        idle(int'($urandom_range(0, 2)));
        px(r, c, 1'b0);
        if (r == 2 && c == 0) pin("gap_col", 1, 0, 16, 32, 2, 0, 0, 0);
      end
    end

    // Back-to-back frame without sof and without an idle between frames.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px(r, c, 1'b0);
        if (r == 2 && c == 0) pin("b2b_col", 1, 0, 16, 32, 2, 0, 0, 0);
      end
    end

    // sof mid-frame at (2,1): restarts the raster.
    for (int i = 0; i < 9; i++) px(i / W, i % W, 1'b0);
    px(0, 0, 1'b1);
    check("sof_vld", int'(vld_o), 0);
    check("sof_row", int'(row_o), 0);
    check("sof_col", int'(col_o), 0);
    for (int i = 1; i < W * H; i++) begin
      px(i / W, i % W, 1'b0);
      if (i == 2 * W) pin("sof_resume", 1, 0, 16, 32, 2, 0, 0, 0);
    end

    // Reset while a pixel is presented at (3,2): pixel dropped.
    for (int i = 0; i < 14; i++) px(i / W, i % W, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16 * 3 + 2);
    pin("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      px(i / W, i % W, 1'b0);
      check("post_rst_vld", int'(vld_o), 0);
    end
    px(2, 0, 1'b0);
    pin("post_rst_col", 1, 0, 16, 32, 2, 0, 0, 0);

    // Long random run: random pixels, gaps, sof and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      automatic int k = int'($urandom_range(0, 99));
      if (k < 2)       step(1'b1, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 255)));
      else if (k < 5)  step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 255)));
      else if (k < 30) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      else             step(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 255)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
